// File: rtl/alu_seq.sv
// Multi-cycle ALU with registered result and flags, a start/busy/done handshake,
// one-bit-per-cycle shifts/rotates and an optional shift-add multiplier.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] lhs_in,
  input  logic [WIDTH-1:0] rhs_in,
  output logic             busy,
  output logic             done,
  input  logic             assert_bus,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_en,
  output logic             flag_zero,
  output logic             flag_acarry,
  output logic             flag_lcarry,
  output logic             flag_sign,
  output logic             flag_overflow
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0] MUL_STEPS = (SW + 1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [3:0]         op_r;
  logic [SW:0]        cnt;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;

  logic               is_shift, is_mul, imm_multi, imm_clr, cin, imm_ac, imm_ov;
  logic [WIDTH-1:0]   b_eff, imm_res;
  logic [WIDTH:0]     sum;

  assign bus_en   = ~assert_bus;
  assign is_shift = (operation >= 4'd8) && (operation <= 4'd12);
  assign is_mul   = (operation == 4'd13) || (operation == 4'd14);

  // Ops finishing at the accept edge; shifts by 0 fall through to PASS-like behaviour on lhs
  always_comb begin
    b_eff     = rhs_in;
    cin       = 1'b0;
    imm_res   = '0;
    imm_ac    = 1'b0;
    imm_ov    = 1'b0;
    imm_clr   = 1'b0;
    imm_multi = (is_shift && (rhs_in[SW-1:0] != '0)) || (is_mul && MUL_EN);
    case (operation)
      4'd1:    cin = flag_acarry;
      4'd2:    begin b_eff = ~rhs_in; cin = 1'b1;        end
      4'd3:    begin b_eff = ~rhs_in; cin = flag_acarry; end
      default: ;
    endcase
    sum = {1'b0, lhs_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    case (operation)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        imm_res = sum[WIDTH-1:0];
        imm_ac  = sum[WIDTH];
        imm_ov  = (lhs_in[WIDTH-1] ^ sum[WIDTH-1]) & (b_eff[WIDTH-1] ^ sum[WIDTH-1]);
      end
      4'd4:         imm_res = lhs_in & rhs_in;
      4'd5:         imm_res = lhs_in | rhs_in;
      4'd6:         imm_res = lhs_in ^ rhs_in;
      4'd7:         imm_res = ~lhs_in;
      4'd13, 4'd14: imm_clr = 1'b1;
      4'd15:        imm_res = rhs_in;
      default:      imm_res = lhs_in;
    endcase
  end

  logic [WIDTH-1:0]   sh_next, run_res;
  logic               sh_out, run_lc, run_ov;
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] acc_next;

  // One iteration step of the in-flight shift or multiply
  always_comb begin
    sh_next = work;
    sh_out  = 1'b0;
    case (op_r)
      4'd8:    begin sh_next = {work[WIDTH-2:0], 1'b0};           sh_out = work[WIDTH-1]; end
      4'd9:    begin sh_next = {1'b0, work[WIDTH-1:1]};           sh_out = work[0];       end
      4'd10:   begin sh_next = {work[WIDTH-1], work[WIDTH-1:1]};  sh_out = work[0];       end
      4'd11:   begin sh_next = {work[WIDTH-2:0], work[WIDTH-1]};  sh_out = work[WIDTH-1]; end
      4'd12:   begin sh_next = {work[0], work[WIDTH-1:1]};        sh_out = work[0];       end
      default: ;
    endcase
    madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_next = {madd, acc[WIDTH-1:1]};
    run_res  = sh_next;
    run_lc   = sh_out;
    run_ov   = 1'b0;
    if (op_r == 4'd13 || op_r == 4'd14) begin
      run_res = (op_r == 4'd13) ? acc_next[WIDTH-1:0] : acc_next[2*WIDTH-1:WIDTH];
      run_lc  = 1'b0;
      run_ov  = |acc_next[2*WIDTH-1:WIDTH];
    end
  end

  // Handshake FSM; result and flags are only written on the edge that enters FIN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      op_r          <= '0;
      cnt           <= '0;
      work          <= '0;
      mcand         <= '0;
      acc           <= '0;
      bus_out       <= '0;
      flag_zero     <= 1'b0;
      flag_acarry   <= 1'b0;
      flag_lcarry   <= 1'b0;
      flag_sign     <= 1'b0;
      flag_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= operation;
            busy  <= 1'b1;
            work  <= lhs_in;
            mcand <= lhs_in;
            acc   <= {{WIDTH{1'b0}}, rhs_in};
            cnt   <= is_mul ? MUL_STEPS : {1'b0, rhs_in[SW-1:0]};
            if (imm_multi) begin
              state <= RUN;
            end else begin
              state         <= FIN;
              done          <= 1'b1;
              bus_out       <= imm_res;
              flag_zero     <= (imm_res == '0) & ~imm_clr;
              flag_acarry   <= imm_ac;
              flag_lcarry   <= 1'b0;
              flag_sign     <= imm_res[WIDTH-1];
              flag_overflow <= imm_ov;
            end
          end
        end
        RUN: begin
          work <= sh_next;
          acc  <= acc_next;
          cnt  <= cnt - 1'b1;
          if (cnt == (SW + 1)'(1)) begin
            state         <= FIN;
            done          <= 1'b1;
            bus_out       <= run_res;
            flag_zero     <= (run_res == '0);
            flag_acarry   <= 1'b0;
            flag_lcarry   <= run_lc;
            flag_sign     <= run_res[WIDTH-1];
            flag_overflow <= run_ov;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: one MUL_EN=1 instance plus a
// MUL_EN=0 instance that is only started for the disabled-multiplier checks.
module tb_alu_seq;

  logic       alu_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       start0 = 1'b0;
  logic [3:0] operation = 4'd0;
  logic [7:0] lhs_in = 8'h00;
  logic [7:0] rhs_in = 8'h00;
  logic       assert_bus = 1'b1;

  logic       busy, done, bus_en;
  logic [7:0] bus_out;
  logic       f_z, f_ac, f_lc, f_s, f_ov;
  logic       busy0, done0, bus_en0;
  logic [7:0] bus_out0;
  logic       g_z, g_ac, g_lc, g_s, g_ov;

  int n_checks = 0;
  int n_fails  = 0;
  int lat;
  bit saw_done;

  always #5 alu_clk = ~alu_clk;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(alu_clk), .reset_n(reset_n), .start(start), .operation(operation),
    .lhs_in(lhs_in), .rhs_in(rhs_in), .busy(busy), .done(done),
    .assert_bus(assert_bus), .bus_out(bus_out), .bus_en(bus_en),
    .flag_zero(f_z), .flag_acarry(f_ac), .flag_lcarry(f_lc),
    .flag_sign(f_s), .flag_overflow(f_ov)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
    .clk(alu_clk), .reset_n(reset_n), .start(start0), .operation(operation),
    .lhs_in(lhs_in), .rhs_in(rhs_in), .busy(busy0), .done(done0),
    .assert_bus(assert_bus), .bus_out(bus_out0), .bus_en(bus_en0),
    .flag_zero(g_z), .flag_acarry(g_ac), .flag_lcarry(g_lc),
    .flag_sign(g_s), .flag_overflow(g_ov)
  );

  wire [4:0] flags  = {f_z, f_ac, f_lc, f_s, f_ov};
  wire [4:0] flags0 = {g_z, g_ac, g_lc, g_s, g_ov};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for idle, presents one request and returns #1 after the accept edge
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] l, input logic [7:0] r, input bit use0);
    @(negedge alu_clk);
    for (int i = 0; i < 40 && busy; i++) @(negedge alu_clk);
    operation = op;
    lhs_in    = l;
    rhs_in    = r;
    start     = 1'b1;
    start0    = use0;
    @(posedge alu_clk);
    #1;
    start  = 1'b0;
    start0 = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen; -1 if it never comes
  task automatic waitDone(output int latency);
    latency = -1;
    for (int j = 0; j < 40; j++) begin
      if (done) begin
        latency = j;
        return;
      end
      @(posedge alu_clk);
      #1;
    end
  endtask

  initial begin
    #12;
    checkOutput("reset_bus_out", 32'(bus_out), 32'h00);
    checkOutput("reset_flags", 32'(flags), 32'h00);
    checkOutput("reset_busy_done", 32'({busy, done}), 32'h0);
    reset_n = 1'b1;
    checkOutput("bus_en_idle_deasserted", 32'(bus_en), 32'h0);

    applyStimulus(4'd0, 8'hFF, 8'h01, 1'b1);
    waitDone(lat);
    checkOutput("add_latency", 32'(lat), 32'd0);
    checkOutput("add_result", 32'(bus_out), 32'h00);
    checkOutput("add_flags", 32'(flags), 32'b11000);
    checkOutput("mul_dis_pre_flags", 32'(flags0), 32'b11000);

    applyStimulus(4'd1, 8'h10, 8'h20, 1'b0);
    waitDone(lat);
    checkOutput("adc_result", 32'(bus_out), 32'h31);
    checkOutput("adc_flags", 32'(flags), 32'b00000);

    applyStimulus(4'd2, 8'h50, 8'h70, 1'b0);
    waitDone(lat);
    checkOutput("sub1_result", 32'(bus_out), 32'hE0);
    checkOutput("sub1_flags", 32'(flags), 32'b00010);

    applyStimulus(4'd2, 8'h80, 8'h01, 1'b0);
    waitDone(lat);
    checkOutput("sub2_result", 32'(bus_out), 32'h7F);
    checkOutput("sub2_flags", 32'(flags), 32'b01001);

    applyStimulus(4'd8, 8'h81, 8'h03, 1'b0);
    checkOutput("shl_busy_running", 32'({busy, done}), 32'b10);
    assert_bus = 1'b0;
    #1;
    checkOutput("bus_en_running", 32'(bus_en), 32'h1);
    checkOutput("bus_out_holds_running", 32'(bus_out), 32'h7F);
    assert_bus = 1'b1;
    #1;
    checkOutput("bus_en_running_off", 32'(bus_en), 32'h0);
    waitDone(lat);
    checkOutput("shl3_latency", 32'(lat), 32'd3);
    checkOutput("shl3_result", 32'(bus_out), 32'h08);
    checkOutput("shl3_flags", 32'(flags), 32'b00000);

    applyStimulus(4'd12, 8'h01, 8'h01, 1'b0);
    waitDone(lat);
    checkOutput("ror1_latency", 32'(lat), 32'd1);
    checkOutput("ror1_result", 32'(bus_out), 32'h80);
    checkOutput("ror1_flags", 32'(flags), 32'b00110);

    applyStimulus(4'd8, 8'h81, 8'h00, 1'b0);
    waitDone(lat);
    checkOutput("shl0_latency", 32'(lat), 32'd0);
    checkOutput("shl0_result", 32'(bus_out), 32'h81);
    checkOutput("shl0_flags", 32'(flags), 32'b00010);

    applyStimulus(4'd13, 8'h0F, 8'h11, 1'b0);
    waitDone(lat);
    checkOutput("mul_latency", 32'(lat), 32'd8);
    checkOutput("mul_result", 32'(bus_out), 32'hFF);
    checkOutput("mul_flags", 32'(flags), 32'b00010);

    applyStimulus(4'd14, 8'h10, 8'h10, 1'b0);
    waitDone(lat);
    checkOutput("mulh_latency", 32'(lat), 32'd8);
    checkOutput("mulh_result", 32'(bus_out), 32'h01);
    checkOutput("mulh_flags", 32'(flags), 32'b00001);

    applyStimulus(4'd13, 8'h05, 8'h03, 1'b1);
    checkOutput("mul_dis_done", 32'(done0), 32'h1);
    checkOutput("mul_dis_result", 32'(bus_out0), 32'h00);
    checkOutput("mul_dis_flags", 32'(flags0), 32'b00000);
    waitDone(lat);
    checkOutput("mul_en_result", 32'(bus_out), 32'h0F);

    applyStimulus(4'd13, 8'h0F, 8'h11, 1'b0);
    @(negedge alu_clk);
    operation = 4'd4;
    lhs_in    = 8'hAA;
    rhs_in    = 8'h0F;
    start     = 1'b1;
    @(posedge alu_clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("ignore_latency", 32'(lat), 32'd7);
    checkOutput("ignore_result", 32'(bus_out), 32'hFF);
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge alu_clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    checkOutput("ignore_no_extra_done", 32'(saw_done), 32'h0);
    checkOutput("ignore_bus_holds", 32'(bus_out), 32'hFF);

    applyStimulus(4'd13, 8'h0F, 8'h11, 1'b0);
    repeat (3) @(posedge alu_clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_bus_out", 32'(bus_out), 32'h00);
    checkOutput("abort_flags", 32'(flags), 32'h00);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    @(negedge alu_clk);
    reset_n  = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge alu_clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    checkOutput("abort_no_done", 32'(saw_done), 32'h0);

    assert_bus = 1'b0;
    #1;
    checkOutput("bus_en_idle", 32'(bus_en), 32'h1);
    checkOutput("bus_en_idle_dut0", 32'(bus_en0), 32'h1);
    assert_bus = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
